// File: rtl/dlx_branch_pkg.sv
// Shared definitions for the branch resolve stage: FSM encoding, PC step, ERR layout.
package dlx_branch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned PC_INC_DEF = 4;
  localparam int unsigned CNT_W_DEF  = 16;

  localparam int unsigned ERR_W     = 3;
  localparam int unsigned ERR_CMP   = 0;  // shadow zero-compare disagrees with COMP_OUT
  localparam int unsigned ERR_MULTI = 1;  // more than one control-flow class asserted
  localparam int unsigned ERR_ALIGN = 2;  // taken target not word aligned

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
  } result_t;

endpackage

// File: rtl/branch_shadow_check.sv
// Independent recompute of the zero-compare used to cross-check the comparator.
module branch_shadow_check
  import dlx_branch_pkg::*;
(
  input  logic [XLEN-1:0] s,
  input  logic            neg,
  input  logic            comp_out,
  output logic            mismatch_c
);

  logic exp_c;

  // Expected decision: S==0 for BEQZ, inverted for BNEZ.
  always_comb begin
    exp_c      = (s == '0) ^ neg;
    mismatch_c = exp_c ^ comp_out;
  end

endmodule

// File: rtl/branch_resolve_stage.sv
// Branch resolve stage: taken decision, next-PC, fetch redirect, safety flags, taken counter.
module branch_resolve_stage
  import dlx_branch_pkg::*;
#(
  parameter int unsigned PC_INC = PC_INC_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_branch,
  input  logic             is_jump,
  input  logic             is_jreg,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  s,
  input  logic             neg,
  input  logic             comp_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [XLEN-1:0]  target_pc,
  output logic             flush,
  input  logic             flush_ack,
  output logic [ERR_W-1:0] err,
  output logic [CNT_W-1:0] taken_cnt
);

  state_e          state;
  state_e          state_nxt;
  logic            accept;
  logic            mismatch_c;
  logic            multi_hot;
  result_t         res_new;
  logic [XLEN-1:0] seq_pc;
  logic            out_fin;
  logic            ack_fin;
  logic            out_done;
  logic            ack_done;
  logic            out_valid_nxt;
  logic            flush_nxt;
  logic            out_done_nxt;
  logic            ack_done_nxt;

  branch_shadow_check u_shadow (
    .s          (s),
    .neg        (neg),
    .comp_out   (comp_out),
    .mismatch_c (mismatch_c)
  );

  // Decode the incoming op: decision, target (JREG > JUMP > BRANCH), multi-hot detect.
  always_comb begin
    seq_pc        = pc + XLEN'(PC_INC);
    res_new.taken = is_jump | is_jreg | (is_branch & comp_out);
    if (is_jreg) begin
      res_new.target = s;
    end else if (res_new.taken) begin
      res_new.target = seq_pc + imm;
    end else begin
      res_new.target = seq_pc;
    end
    multi_hot = (is_branch & is_jump) | (is_branch & is_jreg) | (is_jump & is_jreg);
  end

  // Redirect completes when both handshakes are done, now or in an earlier cycle.
  always_comb begin
    out_fin = out_done | out_ready;
    ack_fin = ack_done | flush_ack;
    accept  = in_valid & in_ready;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = res_new.taken ? ST_REDIRECT : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (accept) begin
            state_nxt = res_new.taken ? ST_REDIRECT : ST_HOLD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_REDIRECT: begin
        if (out_fin && ack_fin) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: upstream ready and next values of the handshake registers.
  always_comb begin
    in_ready      = 1'b0;
    out_valid_nxt = out_valid;
    flush_nxt     = flush;
    out_done_nxt  = out_done;
    ack_done_nxt  = ack_done;
    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
          out_valid_nxt = 1'b1;
          flush_nxt     = res_new.taken;
          out_done_nxt  = 1'b0;
          ack_done_nxt  = 1'b0;
        end
      end
      ST_HOLD: begin
        in_ready = out_ready;
        if (out_ready) begin
          out_valid_nxt = accept;
          flush_nxt     = accept & res_new.taken;
          out_done_nxt  = 1'b0;
          ack_done_nxt  = 1'b0;
        end
      end
      ST_REDIRECT: begin
        if (out_ready && !out_done) begin
          out_valid_nxt = 1'b0;
          out_done_nxt  = 1'b1;
        end
        if (flush_ack && !ack_done) begin
          flush_nxt    = 1'b0;
          ack_done_nxt = 1'b1;
        end
        if (out_fin && ack_fin) begin
          out_valid_nxt = 1'b0;
          flush_nxt     = 1'b0;
          out_done_nxt  = 1'b0;
          ack_done_nxt  = 1'b0;
        end
      end
      default: begin
        out_valid_nxt = 1'b0;
        flush_nxt     = 1'b0;
        out_done_nxt  = 1'b0;
        ack_done_nxt  = 1'b0;
      end
    endcase
  end

  // Handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      flush     <= 1'b0;
      out_done  <= 1'b0;
      ack_done  <= 1'b0;
    end else begin
      out_valid <= out_valid_nxt;
      flush     <= flush_nxt;
      out_done  <= out_done_nxt;
      ack_done  <= ack_done_nxt;
    end
  end

  // Result registers load only on accept, so they hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken     <= 1'b0;
      target_pc <= '0;
    end else if (accept) begin
      taken     <= res_new.taken;
      target_pc <= res_new.target;
    end
  end

  // Sticky safety flags and saturating taken counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err       <= '0;
      taken_cnt <= '0;
    end else if (accept) begin
      if (is_branch && mismatch_c) begin
        err[ERR_CMP] <= 1'b1;
      end
      if (multi_hot) begin
        err[ERR_MULTI] <= 1'b1;
      end
      if (res_new.taken && (res_new.target[1:0] != 2'b00)) begin
        err[ERR_ALIGN] <= 1'b1;
      end
      if (res_new.taken && (taken_cnt != '1)) begin
        taken_cnt <= taken_cnt + CNT_W'(1);
      end
    end
  end

endmodule
